alarm_ctrl: RTL

- Multi-channel alarm controller for the lab clock. It replaces the single combinational minute/hour compare with NUM_ALARMS independently enabled alarm slots and a registered buzzer.
- Buzz duration is bounded, and the block supports snooze with a limit and explicit dismiss.
- Sits beside the timekeeping counters and consumes their minute-tick pulse and current hours/minutes.

---
 rtl/alarm_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: multi-slot alarm controller for the lab clock.
//
// Evaluates NUM_ALARMS independently enabled hh:mm slots on each minute tick
// and drives a registered buzzer. A ring stops by itself after RING_MINS
// minute ticks. Snooze silences it for SNOOZE_MINS ticks, at most MAX_SNOOZE
// times per event. Dismiss, or disabling the active slot, ends the event.
//
// Ports:
//   clk         system clock, all state on rising edge
//   reset       synchronous, active-high reset
//   tick_min    one-cycle minute pulse (tmin/thrs already hold the new minute)
//   tmin, thrs  current minutes (0..59) and hours (0..23)
//   amin, ahrs  packed slot times, slot i at bits [7i+6:7i]
//   alarm_on    per-slot enable
//   snooze      snooze request level
//   dismiss     dismiss request level
//   buzz        registered buzzer drive
//   buzz_id     slot index of the active (or last) event
//   snooze_cnt  snoozes used in the current event
//   active      high while ringing or snoozed
module alarm_ctrl #(
    parameter int NUM_ALARMS  = 4,
    parameter int RING_MINS   = 2,
    parameter int SNOOZE_MINS = 5,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_min,
    input  logic [6:0]              tmin,
    input  logic [6:0]              thrs,
    input  logic [7*NUM_ALARMS-1:0] amin,
    input  logic [7*NUM_ALARMS-1:0] ahrs,
    input  logic [NUM_ALARMS-1:0]   alarm_on,
    input  logic                    snooze,
    input  logic                    dismiss,
    output logic                    buzz,
    output logic [2:0]              buzz_id,
    output logic [1:0]              snooze_cnt,
    output logic                    active
);

    localparam int RW = $clog2(RING_MINS + 1);
    localparam int SW = $clog2(SNOOZE_MINS + 1);

    localparam logic [RW-1:0] RING_MAX   = RW'(RING_MINS);
    localparam logic [SW-1:0] SNOOZE_MAX = SW'(SNOOZE_MINS);
    localparam logic [1:0]    CNT_MAX    = 2'(MAX_SNOOZE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RING = 2'd1;
    localparam logic [1:0] ST_SNZ  = 2'd2;

    logic [1:0]    state_r, state_nxt_s;
    logic [RW-1:0] ring_tmr_r, ring_nxt_s;
    logic [SW-1:0] snz_tmr_r, snz_nxt_s;
    logic [1:0]    cnt_r, cnt_nxt_s;
    logic [2:0]    id_r, id_nxt_s;
    logic          buzz_r, active_r;

    logic          match_any_s;
    logic [2:0]    match_id_s;
    logic          sel_on_s;
    logic          ring_hit_s;
    logic          snz_hit_s;
    logic          stop_s;

    // Slot compare; scanning downward leaves the lowest matching index.
    always_comb begin
        match_any_s = 1'b0;
        match_id_s  = 3'd0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_on[i] && (tmin == amin[7*i +: 7]) && (thrs == ahrs[7*i +: 7])) begin
                match_any_s = 1'b1;
                match_id_s  = 3'(i);
            end else begin
                match_any_s = match_any_s;
            end
        end
    end

    // Enable bit of the slot that owns the current event.
    always_comb begin
        sel_on_s = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (id_r == 3'(i)) begin
                sel_on_s = alarm_on[i];
            end else begin
                sel_on_s = sel_on_s;
            end
        end
    end

    // Timer expiry is judged on the value the timer would take after this tick.
    assign ring_hit_s = ((ring_tmr_r + RW'(1)) >= RING_MAX);
    assign snz_hit_s  = ((snz_tmr_r + SW'(1)) >= SNOOZE_MAX);
    // Disabling the owning slot ends the event just like dismiss.
    assign stop_s     = dismiss || !sel_on_s;

    // Next-state and datapath decisions; priority is stop > snooze > timer.
    always_comb begin
        state_nxt_s = state_r;
        ring_nxt_s  = ring_tmr_r;
        snz_nxt_s   = snz_tmr_r;
        cnt_nxt_s   = cnt_r;
        id_nxt_s    = id_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_min && match_any_s) begin
                    state_nxt_s = ST_RING;
                    id_nxt_s    = match_id_s;
                    cnt_nxt_s   = 2'd0;
                    ring_nxt_s  = '0;
                    snz_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RING: begin
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 2'd0;
                    ring_nxt_s  = '0;
                    snz_nxt_s   = '0;
                end else if (snooze && (cnt_r < CNT_MAX)) begin
                    state_nxt_s = ST_SNZ;
                    cnt_nxt_s   = cnt_r + 2'd1;
                    snz_nxt_s   = '0;
                end else if (tick_min) begin
                    if (ring_hit_s) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 2'd0;
                        ring_nxt_s  = '0;
                        snz_nxt_s   = '0;
                    end else begin
                        ring_nxt_s  = (ring_tmr_r == RING_MAX) ? ring_tmr_r : ring_tmr_r + RW'(1);
                    end
                end else begin
                    state_nxt_s = ST_RING;
                end
            end
            ST_SNZ: begin
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 2'd0;
                    ring_nxt_s  = '0;
                    snz_nxt_s   = '0;
                end else if (tick_min) begin
                    if (snz_hit_s) begin
                        state_nxt_s = ST_RING;
                        ring_nxt_s  = '0;
                    end else begin
                        snz_nxt_s   = (snz_tmr_r == SNOOZE_MAX) ? snz_tmr_r : snz_tmr_r + SW'(1);
                    end
                end else begin
                    state_nxt_s = ST_SNZ;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 2'd0;
                ring_nxt_s  = '0;
                snz_nxt_s   = '0;
            end
        endcase
    end

    // State and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ring_tmr_r <= '0;
            snz_tmr_r  <= '0;
            cnt_r      <= 2'd0;
            id_r       <= 3'd0;
            buzz_r     <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ring_tmr_r <= ring_nxt_s;
            snz_tmr_r  <= snz_nxt_s;
            cnt_r      <= cnt_nxt_s;
            id_r       <= id_nxt_s;
            buzz_r     <= (state_nxt_s == ST_RING);
            active_r   <= (state_nxt_s != ST_IDLE);
        end
    end

    assign buzz       = buzz_r;
    assign buzz_id    = id_r;
    assign snooze_cnt = cnt_r;
    assign active     = active_r;

endmodule
